// File: rtl/fifo_dest_dispatch_if.sv
// Bus between the main FIFO, the dispatcher and the egress queues.
// Optional feature macro: DISPATCH_CNT_EN adds the per-destination dest_count bus.
interface fifo_dest_dispatch_if #(
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned DEST_BITS = 2
`ifdef DISPATCH_CNT_EN
  ,
  parameter int unsigned CNT_W     = 8
`endif
);
  localparam int unsigned NUM_DEST = 1 << DEST_BITS;

  logic                 fifo_empty;
  logic                 fifo_error;
  logic [DATA_SIZE-1:0] buffer_out;
  logic [NUM_DEST-1:0]  dest_pause;
  logic                 read;
  logic [NUM_DEST-1:0]  dest_write;
  logic [DATA_SIZE-1:0] dest_data;
  logic                 disp_error;
`ifdef DISPATCH_CNT_EN
  logic [NUM_DEST*CNT_W-1:0] dest_count;
`endif

  // Dispatcher side
  modport master (
    input  fifo_empty, fifo_error, buffer_out, dest_pause,
`ifdef DISPATCH_CNT_EN
    output dest_count,
`endif
    output read, dest_write, dest_data, disp_error
  );

  // FIFO / egress side
  modport slave (
    output fifo_empty, fifo_error, buffer_out, dest_pause,
`ifdef DISPATCH_CNT_EN
    input  dest_count,
`endif
    input  read, dest_write, dest_data, disp_error
  );
endinterface

// File: rtl/fifo_dest_dispatch.sv
// Drain stage behind the main FIFO: pops one word at a time, decodes the
// destination field in the top DEST_BITS and writes it to one egress queue.
// Optional feature macro: DISPATCH_CNT_EN adds per-destination word counters.
module fifo_dest_dispatch #(
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned DEST_BITS = 2
`ifdef DISPATCH_CNT_EN
  ,
  parameter int unsigned CNT_W     = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_dest_dispatch_if.master bus
);
  localparam int unsigned NUM_DEST = 1 << DEST_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [DEST_BITS-1:0] dest_q, dest_d;
  logic                 err_q, err_d;
  logic [NUM_DEST-1:0]  dest_write_q, dest_write_d;
  logic [DATA_SIZE-1:0] dest_data_q, dest_data_d;
  logic                 can_read;
  logic                 go;
  logic                 read_c;

  // A pop is allowed only with data present, no error seen and not in reset
  assign can_read = !bus.fifo_empty && !err_q && !reset;
  // Held word may leave only when its egress is not paused
  assign go       = (state_q == ST_HOLD) && !bus.dest_pause[dest_q];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      dest_q       <= '0;
      err_q        <= 1'b0;
      dest_write_q <= '0;
      dest_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      err_q        <= err_d;
      dest_write_q <= dest_write_d;
      dest_data_q  <= dest_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (can_read) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (go) state_d = can_read ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    read_c       = 1'b0;
    data_d       = data_q;
    dest_d       = dest_q;
    err_d        = err_q | bus.fifo_error;
    dest_write_d = '0;
    dest_data_d  = dest_data_q;
    unique case (state_q)
      ST_IDLE: read_c = can_read;
      ST_WAIT: begin
        data_d = bus.buffer_out;
        dest_d = bus.buffer_out[DATA_SIZE-1 -: DEST_BITS];
      end
      ST_HOLD: begin
        if (go) begin
          dest_write_d = NUM_DEST'(1) << dest_q;
          dest_data_d  = data_q;
          read_c       = can_read;
        end
      end
      default: ;
    endcase
  end

  assign bus.read       = read_c;
  assign bus.dest_write = dest_write_q;
  assign bus.dest_data  = dest_data_q;
  assign bus.disp_error = err_q;

`ifdef DISPATCH_CNT_EN
  logic [NUM_DEST-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Count words per destination on the edge that raises dest_write
  always_comb begin
    cnt_d = cnt_q;
    if (go) cnt_d[dest_q] = cnt_q[dest_q] + CNT_W'(1);
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.dest_count = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_dest_dispatch.sv
// Directed bench for fifo_dest_dispatch with a small FIFO model on the read side.
// Optional feature macro: DISPATCH_CNT_EN enables the dest_count checks.
module tb_fifo_dest_dispatch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_dest_dispatch_if dif ();
  fifo_dest_dispatch dut (.clk(clk), .reset(reset), .bus(dif.master));

  int n_tests = 0;
  int n_fail  = 0;
  int n_reads = 0;
  int cyc;

  // FIFO model: bench pushes via wr_ptr, DUT pops via read
  logic [5:0] mem [512];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign dif.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (dif.read && rd_ptr != wr_ptr) begin
      dif.buffer_out <= mem[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
      n_reads        <= n_reads + 1;
    end
  end

  logic [3:0] st_wexp [1:10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
  logic [5:0] st_dexp [1:10] = '{6'h00, 6'h00, 6'h03, 6'h00, 6'h17, 6'h00, 6'h2A, 6'h00, 6'h3F, 6'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Advance until a dest_write pulse is seen; cyc = -1 if the bound expires
  task automatic wait_write(input int max_cyc, output int c);
    c = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk); #1;
      if (dif.dest_write != '0) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    dif.fifo_error = 1'b0;
    dif.dest_pause = '0;
    dif.buffer_out = '0;
    push(6'h25);

    // Reset held with FIFO non-empty
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rst_read",  32'(dif.read), 32'd0);
      check("rst_write", 32'(dif.dest_write), 32'd0);
      check("rst_data",  32'(dif.dest_data), 32'd0);
      check("rst_err",   32'(dif.disp_error), 32'd0);
    end

    // Single word 6'b10_0101 to dest 2
    @(negedge clk); reset = 1'b0; #1;
    check("sw_read", 32'(dif.read), 32'd1);
    wait_write(8, cyc);
    check("sw_lat",   32'(cyc), 32'd3);
    check("sw_write", 32'(dif.dest_write), 32'h4);
    check("sw_data",  32'(dif.dest_data), 32'h25);
    @(negedge clk); #1;
    check("sw_pulse", 32'(dif.dest_write), 32'd0);
    check("sw_hold",  32'(dif.dest_data), 32'h25);
    check("sw_idle",  32'(dif.read), 32'd0);
    check("sw_nrd",   32'(n_reads), 32'd1);

    // Streaming four words back-to-back
    @(negedge clk);
    push(6'h03); push(6'h17); push(6'h2A); push(6'h3F);
    #1;
    check("st_read0", 32'(dif.read), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      check("st_write", 32'(dif.dest_write), 32'(st_wexp[k]));
      if (st_wexp[k] != 4'h0) check("st_data", 32'(dif.dest_data), 32'(st_dexp[k]));
    end
    check("st_read", 32'(dif.read), 32'd0);
    check("st_nrd",  32'(n_reads), 32'd5);

    // Pause on dest 3 for five HOLD cycles with another word queued
    @(negedge clk);
    dif.dest_pause = 4'b1000;
    push(6'h31); push(6'h05);
    #1;
    check("pz_read0", 32'(dif.read), 32'd1);
    @(negedge clk); #1;
    check("pz_wait", 32'(dif.read), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("pz_stall_rd", 32'(dif.read), 32'd0);
      check("pz_stall_wr", 32'(dif.dest_write), 32'd0);
    end
    @(negedge clk); dif.dest_pause = 4'b0000; #1;
    check("pz_b2b_rd", 32'(dif.read), 32'd1);
    @(negedge clk); dif.dest_pause = 4'b1111; #1;
    check("pz_write", 32'(dif.dest_write), 32'h8);
    check("pz_data",  32'(dif.dest_data), 32'h31);
    @(negedge clk); dif.dest_pause = 4'b0000; #1;
    check("pz_pulse", 32'(dif.dest_write), 32'd0);
    @(negedge clk); #1;
    check("pz_write2", 32'(dif.dest_write), 32'h1);
    check("pz_data2",  32'(dif.dest_data), 32'h05);

    // Error pulse while a word sits in HOLD
    @(negedge clk);
    dif.dest_pause = 4'b0010;
    push(6'h12); push(6'h3C);
    #1;
    check("er_read0", 32'(dif.read), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); dif.fifo_error = 1'b1; #1;
    check("er_err_early", 32'(dif.disp_error), 32'd0);
    @(negedge clk); dif.fifo_error = 1'b0; dif.dest_pause = 4'b0000; #1;
    check("er_err_set", 32'(dif.disp_error), 32'd1);
    check("er_no_b2b",  32'(dif.read), 32'd0);
    @(negedge clk); #1;
    check("er_write", 32'(dif.dest_write), 32'h2);
    check("er_data",  32'(dif.dest_data), 32'h12);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("er_noread", 32'(dif.read), 32'd0);
      check("er_sticky", 32'(dif.disp_error), 32'd1);
      check("er_nowr",   32'(dif.dest_write), 32'd0);
    end
    check("er_nrd", 32'(n_reads), 32'd8);

    // Reset clears the error; then reset while a word is held
    @(negedge clk); reset = 1'b1; #1;
    check("rm_rst_rd", 32'(dif.read), 32'd0);
    @(negedge clk); reset = 1'b0; dif.dest_pause = 4'b1000; push(6'h01); #1;
    check("rm_err_clr", 32'(dif.disp_error), 32'd0);
    check("rm_read0",   32'(dif.read), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); reset = 1'b1; #1;
    check("rm_rst_rd2", 32'(dif.read), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    check("rm_nowr",  32'(dif.dest_write), 32'd0);
    check("rm_read1", 32'(dif.read), 32'd1);
`ifdef DISPATCH_CNT_EN
    check("rm_cnt_clr", dif.dest_count, 32'd0);
`endif
    wait_write(8, cyc);
    check("rm_lat",   32'(cyc), 32'd3);
    check("rm_write", 32'(dif.dest_write), 32'h1);
    check("rm_data",  32'(dif.dest_data), 32'h01);
`ifdef DISPATCH_CNT_EN
    check("cn_one", dif.dest_count, 32'h0000_0001);

    // Counter wrap on dest 0
    @(negedge clk);
    dif.dest_pause = 4'b0000;
    for (int k = 0; k < 254; k++) push(6'h0A);
    repeat (254 * 2 + 8) @(negedge clk);
    #1;
    check("cn_255", dif.dest_count, 32'h0000_00FF);
    push(6'h0A);
    repeat (8) @(negedge clk);
    #1;
    check("cn_wrap", dif.dest_count, 32'h0000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
